// File: rtl/jt6295_pkg.sv
// Shared constants and types for the ADPCM ROM access scheduler.
package jt6295_pkg;
  localparam int AW       = 18;
  localparam int NREQ     = 5;
  localparam int CTRL_IDX = 4;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT
  } state_t;
endpackage

// File: rtl/jt6295_rom_sched_if.sv
// External ADPCM ROM port: the scheduler drives address/select, the ROM returns data/ok.
interface jt6295_rom_sched_if #(
  parameter int AW = jt6295_pkg::AW
) ();
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (output rom_addr, rom_cs, input rom_data, rom_ok);
  modport slave  (input rom_addr, rom_cs, output rom_data, rom_ok);
endinterface

// File: rtl/jt6295_rom_slot.sv
// One-entry cache for a single ROM requester; hit is a combinational tag compare.
module jt6295_rom_slot #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [AW-1:0] wtag,
  input  logic [7:0]    wdata,
  output logic [7:0]    dout,
  output logic          ok
);
  logic [AW-1:0] tag;
  logic [7:0]    data;
  logic          valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (we) begin
      tag   <= wtag;
      data  <= wdata;
      valid <= 1'b1;
    end
  end

  assign dout = data;
  assign ok   = valid && (tag == addr);
endmodule

// File: rtl/jt6295_rom_sched.sv
// Shares the ADPCM ROM port between the ctrl fetcher (top priority) and four
// round-robin channel fetchers, each fronted by a one-entry cache slot.
module jt6295_rom_sched #(
  parameter int AW     = 18,
  parameter int SETTLE = 1,
  parameter int TOUT   = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_req,
  input  logic [AW-1:0]         ctrl_addr,
  output logic [7:0]            ctrl_dout,
  output logic                  ctrl_ok,
  input  logic [3:0]            ch_req,
  input  logic [4*AW-1:0]       ch_addr,
  output logic [31:0]           ch_dout,
  output logic [3:0]            ch_ok,
  jt6295_rom_sched_if.master    rom,
  output logic                  tout_err
);
  import jt6295_pkg::*;

  state_t              state, state_nx;
  logic [NREQ-1:0]     req, ok, pend, slot_we;
  logic [AW-1:0]       addr [NREQ];
  logic [7:0]          dout [NREQ];
  logic [AW-1:0]       gaddr, rom_addr_r;
  logic [2:0]          gsel, grant_idx;
  logic [1:0]          rr, cand, settle;
  logic [7:0]          tcnt;
  logic                grant_any, fill, abort, rom_cs_r;

  assign req  = {ctrl_req, ch_req};
  assign pend = req & ~ok;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) addr[i] = ch_addr[i*AW +: AW];
    addr[CTRL_IDX] = ctrl_addr;
  end

  always_comb begin
    ch_dout = '0;
    for (int unsigned i = 0; i < 4; i++) ch_dout[i*8 +: 8] = dout[i];
  end

  assign ch_ok     = ok[3:0];
  assign ctrl_ok   = ok[CTRL_IDX];
  assign ctrl_dout = dout[CTRL_IDX];

  // Channel search starts one past the last channel served, so each waits at most three others.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (pend[CTRL_IDX]) begin
      grant_any = 1'b1;
      grant_idx = 3'(CTRL_IDX);
    end else begin
      for (int unsigned k = 1; k <= 4; k++) begin
        cand = rr + 2'(k);
        if (!grant_any && pend[{1'b0, cand}]) begin
          grant_any = 1'b1;
          grant_idx = {1'b0, cand};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = ADDR;
      ADDR:    state_nx = WAIT;
      WAIT:    if (fill || abort) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rom_ok is only trusted once the settle window after the address change has elapsed.
  always_comb begin
    fill    = (state == WAIT) && (settle == 2'd0) && rom.rom_ok;
    abort   = (state == WAIT) && !fill && (tcnt == 8'(TOUT - 1));
    slot_we = '0;
    if (fill) slot_we[gsel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_r <= '0;
      rom_cs_r   <= 1'b0;
      settle     <= '0;
      tcnt       <= '0;
      gaddr      <= '0;
      gsel       <= '0;
      rr         <= '0;
      tout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          gsel  <= grant_idx;
          gaddr <= addr[grant_idx];
          if (grant_idx != 3'(CTRL_IDX)) rr <= grant_idx[1:0];
        end
        ADDR: begin
          rom_addr_r <= gaddr;
          rom_cs_r   <= 1'b1;
          settle     <= 2'(SETTLE);
          tcnt       <= '0;
        end
        WAIT: begin
          if (settle != 2'd0) settle <= settle - 2'd1;
          tcnt <= tcnt + 8'd1;
          if (fill || abort) rom_cs_r <= 1'b0;
          if (abort) tout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rom.rom_addr = rom_addr_r;
  assign rom.rom_cs   = rom_cs_r;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    jt6295_rom_slot #(.AW(AW)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (addr[i]),
      .we    (slot_we[i]),
      .wtag  (gaddr),
      .wdata (rom.rom_data),
      .dout  (dout[i]),
      .ok    (ok[i])
    );
  end
endmodule
